time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
- Button-driven controller that sequences editing of the wall-clock time and the alarm time for the digital clock core.
- Captures the current value and lets the user step through hour, minute and (for the clock only) second fields with increment/decrement.
- Issues a single-cycle load strobe with the edited value to either the clock core or the alarm register.
- Sits between the debounced button logic and the clock/alarm datapath; all logic runs on the 1 Hz-class system clock.

Parameters:
- TIMEOUT, 30, idle cycles without any button pulse before an edit is aborted (30 s at 1 Hz).

Ports:
- clk  in  1  system clock, rising edge.
- r  in  1  synchronous active-high reset.
- btn_mode  in  1  one-cycle pulse: enter edit from IDLE, or abort an edit.
- btn_next  in  1  one-cycle pulse: advance to the next field, or commit after the last field.
- btn_inc  in  1  one-cycle pulse: increment the current field.
- btn_dec  in  1  one-cycle pulse: decrement the current field.
- target  in  1  0 = edit clock, 1 = edit alarm; sampled only on entry to edit.
- cur_h  in  5  current clock hour, 0..23.
- cur_m  in  6  current clock minute, 0..59.
- cur_s  in  6  current clock second, 0..59.
- alm_h  in  5  stored alarm hour, 0..23.
- alm_m  in  6  stored alarm minute, 0..59.
- set_h  out  5  edited hour.
- set_m  out  6  edited minute.
- set_s  out  6  edited second; always 0 for alarm edits.
- field  out  2  field being edited: 0 none, 1 hour, 2 minute, 3 second.
- busy  out  1  high in any edit state and in COMMIT.
- clk_load  out  1  one-cycle strobe: load set_h/m/s into the clock core.
- alm_load  out  1  one-cycle strobe: load set_h/m into the alarm.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Buttons are clean one-cycle pulses from upstream.
- Reset (r=1 at a clock edge), regardless of state:
  - State goes to IDLE.
  - set_h/m/s = 0, field = 0, busy = 0, clk_load = 0, alm_load = 0.
  - Target latch and timeout counter are cleared.
  - An edit in progress is discarded and no load is issued.
- States: IDLE, E_HOUR, E_MIN, E_SEC, COMMIT.
- IDLE:
  - btn_mode: latch target.
  - If target=0, load edit registers from cur_h/m/s. If target=1, load from alm_h, alm_m, and set second to 0.
  - Go to E_HOUR on the next cycle (field=1, busy=1).
  - All other buttons are ignored.
- Button priority when several pulse in the same cycle: mode > next > inc > dec. Only the highest-priority one acts.
- Edit states:
  - btn_mode: abort to IDLE with no load. Edit registers keep their values.
  - btn_next: E_HOUR → E_MIN. E_MIN → E_SEC for clock, or → COMMIT for alarm. E_SEC → COMMIT.
  - btn_inc / btn_dec: modify the current field by ±1, registered, visible the next cycle.
- Field arithmetic:
  - Hour: modulo 24; 23+1 → 0, 0−1 → 23.
  - Minute and second: modulo 60; 59+1 → 0, 0−1 → 59.
  - Fields are independent: no carry or borrow into the adjacent field.
- COMMIT:
  - Lasts exactly one cycle, with field=0 and busy=1.
  - Asserts clk_load if the latched target is 0, otherwise alm_load. Never both.
  - set_* hold the committed values during the strobe.
  - Then goes to IDLE. Buttons during COMMIT are ignored.
- Latency: COMMIT (load strobe) is the cycle immediately after the btn_next pulse on the last field.
- Timeout:
  - The counter clears on entry to E_HOUR and on any button pulse.
  - It increments every other cycle spent in an edit state.
  - When it reaches TIMEOUT−1 with no button that cycle, the next state is IDLE with no load.
- Input isolation:
  - cur_* and alm_* changes during an edit do not affect the edit registers.
  - target changes during an edit are ignored.
- Outputs are fully registered. set_* are held in IDLE after commit or abort until the next edit entry.

Test Plan:
- Reset mid-edit: r=1 while in E_MIN with set_m=17 → next cycle IDLE, all outputs 0, no load strobe.
- Clock edit: cur=23:59:58, target=0; mode, inc, next, dec, next, inc, next → set=00:58:59, clk_load high for exactly 1 cycle, alm_load never asserted.
- Alarm edit: alm=06:30, target=1; mode, next, inc×30, next → set=06:00:00, alm_load for 1 cycle, E_SEC never visited (field never 3).
- Priority and abort: btn_mode and btn_next pulse together in E_HOUR → IDLE, no load; btn_inc and btn_dec together → +1 only.
- Timeout: TIMEOUT=30, enter edit, one inc at cycle 10 → still editing at cycle 38, IDLE after 30 idle cycles following the inc, no load.
- Isolation: target toggles and cur_* change during the edit → committed value uses the entry snapshot, and the load goes to the target latched at entry.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Button-driven editor for wall-clock and alarm time; one-cycle load strobe on commit.
// Every output is a register loaded from the next-state logic, so outputs change with the state.
module time_set_ctrl #(
   parameter int TIMEOUT = 30
) (
   input  logic       clk,
   input  logic       r,
   input  logic       btn_mode,
   input  logic       btn_next,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic       target,
   input  logic [4:0] cur_h,
   input  logic [5:0] cur_m,
   input  logic [5:0] cur_s,
   input  logic [4:0] alm_h,
   input  logic [5:0] alm_m,
   output logic [4:0] set_h,
   output logic [5:0] set_m,
   output logic [5:0] set_s,
   output logic [1:0] field,
   output logic       busy,
   output logic       clk_load,
   output logic       alm_load
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_HOUR, S_MIN, S_SEC, S_COMMIT} state_t;

   state_t          r_state, w_state_nxt;
   logic            r_tgt, w_tgt_nxt;
   logic [4:0]      r_h, w_h_nxt;
   logic [5:0]      r_m, w_m_nxt;
   logic [5:0]      r_s, w_s_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [1:0]      r_field, w_field_nxt;
   logic            r_busy, w_busy_nxt;
   logic            r_clk_load, w_clk_load_nxt;
   logic            r_alm_load, w_alm_load_nxt;
   logic            w_btn;

   // Wrapping +/-1 within 0..top; no carry into neighbouring fields.
   function automatic logic [5:0] f_step(input logic [5:0] v, input logic [5:0] top,
                                         input logic up);
      if (up) return (v == top) ? 6'd0 : v + 6'd1;
      else    return (v == 6'd0) ? top : v - 6'd1;
   endfunction

   assign w_btn = btn_mode | btn_next | btn_inc | btn_dec;

   always_comb begin
      w_state_nxt = r_state;
      w_tgt_nxt   = r_tgt;
      w_h_nxt     = r_h;
      w_m_nxt     = r_m;
      w_s_nxt     = r_s;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (btn_mode) begin
               w_tgt_nxt   = target;
               w_h_nxt     = target ? alm_h : cur_h;
               w_m_nxt     = target ? alm_m : cur_m;
               w_s_nxt     = target ? 6'd0  : cur_s;
               w_cnt_nxt   = '0;
               w_state_nxt = S_HOUR;
            end
         end
         S_HOUR, S_MIN, S_SEC: begin
            if (btn_mode) begin
               w_state_nxt = S_IDLE;
            end else if (btn_next) begin
               if (r_state == S_HOUR)                 w_state_nxt = S_MIN;
               else if (r_state == S_MIN && !r_tgt)   w_state_nxt = S_SEC;
               else                                   w_state_nxt = S_COMMIT;
            end else if (btn_inc || btn_dec) begin
               // inc outranks dec when both pulse together
               if (r_state == S_HOUR)     w_h_nxt = 5'(f_step({1'b0, r_h}, 6'd23, btn_inc));
               else if (r_state == S_MIN) w_m_nxt = f_step(r_m, 6'd59, btn_inc);
               else                       w_s_nxt = f_step(r_s, 6'd59, btn_inc);
            end
            if (w_btn) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == CW'(TIMEOUT - 1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_COMMIT: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase

      w_field_nxt    = 2'd0;
      w_busy_nxt     = 1'b0;
      w_clk_load_nxt = 1'b0;
      w_alm_load_nxt = 1'b0;
      case (w_state_nxt)
         S_HOUR:   begin w_field_nxt = 2'd1; w_busy_nxt = 1'b1; end
         S_MIN:    begin w_field_nxt = 2'd2; w_busy_nxt = 1'b1; end
         S_SEC:    begin w_field_nxt = 2'd3; w_busy_nxt = 1'b1; end
         S_COMMIT: begin
            w_busy_nxt     = 1'b1;
            w_clk_load_nxt = ~w_tgt_nxt;
            w_alm_load_nxt = w_tgt_nxt;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (r) begin
         r_state    <= S_IDLE;
         r_tgt      <= 1'b0;
         r_h        <= '0;
         r_m        <= '0;
         r_s        <= '0;
         r_cnt      <= '0;
         r_field    <= '0;
         r_busy     <= 1'b0;
         r_clk_load <= 1'b0;
         r_alm_load <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tgt      <= w_tgt_nxt;
         r_h        <= w_h_nxt;
         r_m        <= w_m_nxt;
         r_s        <= w_s_nxt;
         r_cnt      <= w_cnt_nxt;
         r_field    <= w_field_nxt;
         r_busy     <= w_busy_nxt;
         r_clk_load <= w_clk_load_nxt;
         r_alm_load <= w_alm_load_nxt;
      end
   end

   assign set_h    = r_h;
   assign set_m    = r_m;
   assign set_s    = r_s;
   assign field    = r_field;
   assign busy     = r_busy;
   assign clk_load = r_clk_load;
   assign alm_load = r_alm_load;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed and random stimulus for time_set_ctrl, checked every cycle against a field-list model.
module tb_time_set_ctrl;
   localparam int TIMEOUT = 30;

   logic       clk = 1'b0;
   logic       r = 1'b1;
   logic       btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
   logic       target = 1'b0;
   logic [4:0] cur_h = '0, alm_h = '0;
   logic [5:0] cur_m = '0, cur_s = '0, alm_m = '0;
   logic [4:0] set_h;
   logic [5:0] set_m, set_s;
   logic [1:0] field;
   logic       busy, clk_load, alm_load;

   time_set_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .r(r), .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
      .btn_dec(btn_dec), .target(target), .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
      .alm_h(alm_h), .alm_m(alm_m), .set_h(set_h), .set_m(set_m), .set_s(set_s),
      .field(field), .busy(busy), .clk_load(clk_load), .alm_load(alm_load)
   );

   always #5 clk = ~clk;

   int n_asrt = 0;
   int n_fail = 0;

   // Model: an edit walks a list of fields (hour, minute[, second]) by index.
   bit m_edit, m_commit, m_tgt;
   int m_idx, m_quiet;
   int m_v[3];
   int clk_loads, alm_loads;
   bit saw_f3;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int nf, md;
      if (r) begin
         m_edit = 0; m_commit = 0; m_tgt = 0; m_quiet = 0; m_idx = 0;
         m_v[0] = 0; m_v[1] = 0; m_v[2] = 0;
      end else if (m_commit) begin
         m_commit = 0;
      end else if (!m_edit) begin
         if (btn_mode) begin
            m_tgt  = target;
            m_v[0] = target ? int'(alm_h) : int'(cur_h);
            m_v[1] = target ? int'(alm_m) : int'(cur_m);
            m_v[2] = target ? 0 : int'(cur_s);
            m_edit = 1; m_idx = 0; m_quiet = 0;
         end
      end else begin
         nf = m_tgt ? 2 : 3;
         if (btn_mode) m_edit = 0;
         else if (btn_next) begin
            if (m_idx == nf - 1) begin m_edit = 0; m_commit = 1; end
            else m_idx++;
         end else if (btn_inc || btn_dec) begin
            md = (m_idx == 0) ? 24 : 60;
            m_v[m_idx] = (m_v[m_idx] + md + (btn_inc ? 1 : -1)) % md;
         end
         if (btn_mode || btn_next || btn_inc || btn_dec) m_quiet = 0;
         else begin
            m_quiet++;
            if (m_quiet >= TIMEOUT) m_edit = 0;
         end
      end
   endtask

   task automatic check_outputs();
      chk("set_h", 32'(set_h), 32'(m_v[0]));
      chk("set_m", 32'(set_m), 32'(m_v[1]));
      chk("set_s", 32'(set_s), 32'(m_v[2]));
      chk("field", 32'(field), m_edit ? 32'(m_idx + 1) : 32'd0);
      chk("busy", 32'(busy), 32'(m_edit || m_commit));
      chk("clk_load", 32'(clk_load), 32'(m_commit && !m_tgt));
      chk("alm_load", 32'(alm_load), 32'(m_commit && m_tgt));
      clk_loads += int'(clk_load);
      alm_loads += int'(alm_load);
      if (field == 2'd3) saw_f3 = 1;
   endtask

   task automatic cyc(input bit mo, input bit nx, input bit in, input bit de);
      btn_mode = mo; btn_next = nx; btn_inc = in; btn_dec = de;
      @(posedge clk);
      #1;
      model_step();
      btn_mode = 0; btn_next = 0; btn_inc = 0; btn_dec = 0;
      check_outputs();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      r = 1;
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      r = 0;
      chk("rst_busy", 32'(busy), 32'd0);

      // reset mid-edit while minute is 17
      target = 0; cur_h = 5'd4; cur_m = 6'd17; cur_s = 6'd9;
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      chk("pre_rst_m", 32'(set_m), 32'd17);
      r = 1;
      cyc(0, 0, 0, 0);
      r = 0;
      chk("rst_set_m", 32'(set_m), 32'd0);
      chk("rst_field", 32'(field), 32'd0);
      cyc(0, 0, 0, 0);

      // clock edit 23:59:58 -> 00:58:59
      clk_loads = 0; alm_loads = 0;
      target = 0; cur_h = 5'd23; cur_m = 6'd59; cur_s = 6'd58;
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 1);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 1, 0, 0);
      chk("clk_set_h", 32'(set_h), 32'd0);
      chk("clk_set_m", 32'(set_m), 32'd58);
      chk("clk_set_s", 32'(set_s), 32'd59);
      chk("clk_strobe", 32'(clk_load), 32'd1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("clk_load_cnt", 32'(clk_loads), 32'd1);
      chk("clk_alm_cnt", 32'(alm_loads), 32'd0);

      // alarm edit 06:30 with inputs and target disturbed mid-edit
      clk_loads = 0; alm_loads = 0; saw_f3 = 0;
      target = 1; alm_h = 5'd6; alm_m = 6'd30;
      cyc(1, 0, 0, 0);
      target = 0; alm_h = 5'd12; alm_m = 6'd5; cur_h = 5'd1;
      cyc(0, 1, 0, 0);
      for (int i = 0; i < 30; i++) cyc(0, 0, 1, 0);
      cyc(0, 1, 0, 0);
      chk("alm_set_h", 32'(set_h), 32'd6);
      chk("alm_set_m", 32'(set_m), 32'd0);
      chk("alm_set_s", 32'(set_s), 32'd0);
      cyc(0, 0, 0, 0);
      chk("alm_load_cnt", 32'(alm_loads), 32'd1);
      chk("alm_clk_cnt", 32'(clk_loads), 32'd0);
      chk("alm_no_sec", 32'(saw_f3), 32'd0);

      // priority: mode+next aborts, inc+dec increments
      clk_loads = 0; alm_loads = 0;
      target = 0; cur_h = 5'd10; cur_m = 6'd0; cur_s = 6'd0;
      cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0);
      chk("prio_abort", 32'(busy), 32'd0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 1);
      chk("prio_incdec", 32'(set_h), 32'd11);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 1);
      chk("min_wrap", 32'(set_m), 32'd59);
      cyc(1, 0, 0, 0);
      chk("prio_loads", 32'(clk_loads + alm_loads), 32'd0);

      // timeout: entry at cycle 0, inc at cycle 10
      cyc(1, 0, 0, 0);
      for (int i = 1; i < 10; i++) cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      for (int i = 11; i <= 40; i++) begin
         cyc(0, 0, 0, 0);
         if (i == 38) chk("to_busy38", 32'(busy), 32'd1);
      end
      chk("to_idle", 32'(busy), 32'd0);
      chk("to_loads", 32'(clk_loads + alm_loads), 32'd0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         r      = ($urandom_range(99, 0) == 0);
         target = 1'($urandom_range(1, 0));
         cur_h  = 5'($urandom_range(23, 0));
         cur_m  = 6'($urandom_range(59, 0));
         cur_s  = 6'($urandom_range(59, 0));
         alm_h  = 5'($urandom_range(23, 0));
         alm_m  = 6'($urandom_range(59, 0));
         cyc($urandom_range(11, 0) == 0, $urandom_range(5, 0) == 0,
             $urandom_range(2, 0) == 0, $urandom_range(2, 0) == 0);
      end
      r = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
